// File: rtl/tqvp_vga_timing_gen.sv
// Raster timing for the TinyQV VGA peripheral: counters, sync/blank decodes,
// per-line retrace strobe and a sticky hblank/vblank interrupt.
module tqvp_vga_timing_gen #(
  parameter int unsigned H_VISIBLE    = 1024,
  parameter int unsigned H_NARROW     = 960,
  parameter int unsigned H_FRONT      = 24,
  parameter int unsigned H_SYNC       = 136,
  parameter int unsigned H_BACK       = 144,
  parameter int unsigned V_VISIBLE    = 768,
  parameter int unsigned V_FRONT      = 3,
  parameter int unsigned V_SYNC       = 6,
  parameter int unsigned V_BACK_LONG  = 27,
  parameter int unsigned V_BACK_SHORT = 21
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cli,
  input  logic        enable_interrupt_on_hblank,
  input  logic        enable_interrupt_on_vblank,
  input  logic        narrow_960,
  input  logic        extra_vblank_lines_for_64mhz,
  output logic [10:0] x,
  output logic [9:0]  y,
  output logic        hsync,
  output logic        vsync,
  output logic        retrace,
  output logic        blank,
  output logic        interrupt
);

  localparam int unsigned X_W           = 11;
  localparam int unsigned Y_W           = 10;
  localparam int unsigned H_TOTAL       = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int unsigned V_TOTAL_LONG  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK_LONG;
  localparam int unsigned V_TOTAL_SHORT = V_VISIBLE + V_FRONT + V_SYNC + V_BACK_SHORT;
  localparam int unsigned HS_START      = H_VISIBLE + H_FRONT;
  localparam int unsigned HS_END        = HS_START + H_SYNC;
  localparam int unsigned VS_START      = V_VISIBLE + V_FRONT;
  localparam int unsigned VS_END        = VS_START + V_SYNC;

  logic           n_q;
  logic           s_q;
  logic [X_W-1:0] h_active;
  logic [Y_W-1:0] v_last;
  logic           line_end;
  logic           frame_end;
  logic           set_h;
  logic           set_v;

  // Mode-dependent limits and interrupt set events, all from the current x/y
  always_comb begin
    h_active  = n_q ? X_W'(H_NARROW) : X_W'(H_VISIBLE);
    v_last    = s_q ? Y_W'(V_TOTAL_SHORT - 1) : Y_W'(V_TOTAL_LONG - 1);
    line_end  = (x == X_W'(H_TOTAL - 1));
    frame_end = line_end && (y == v_last);
    set_h     = enable_interrupt_on_hblank && (x == h_active) && (y < Y_W'(V_VISIBLE));
    set_v     = enable_interrupt_on_vblank && (x == '0) && (y == Y_W'(V_VISIBLE));
  end

  // Sync position is fixed to the wide-mode timing so narrow mode only widens blanking
  assign hsync   = !((x >= X_W'(HS_START)) && (x < X_W'(HS_END)));
  assign vsync   = !((y >= Y_W'(VS_START)) && (y < Y_W'(VS_END)));
  assign blank   = (x >= h_active) || (y >= Y_W'(V_VISIBLE));
  assign retrace = line_end;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x <= '0;
      y <= '0;
    end else if (line_end) begin
      x <= '0;
      y <= frame_end ? '0 : y + Y_W'(1);
    end else begin
      x <= x + X_W'(1);
    end
  end

  // Narrow applies from the next line, frame length from the next frame
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= 1'b0;
      s_q <= 1'b0;
    end else begin
      if (line_end)  n_q <= narrow_960;
      if (frame_end) s_q <= extra_vblank_lines_for_64mhz;
    end
  end

  // A new set event beats a simultaneous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      interrupt <= 1'b0;
    end else if (set_h || set_v) begin
      interrupt <= 1'b1;
    end else if (cli) begin
      interrupt <= 1'b0;
    end
  end

endmodule

// File: tb/tb_tqvp_vga_timing_gen.sv
// Bench for tqvp_vga_timing_gen: a full-size instance for line timing and a
// scaled instance for frame/vblank behaviour, both tracked by a raster model.
module tb_tqvp_vga_timing_gen;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cli = 1'b0;
  logic en_h = 1'b0;
  logic en_v = 1'b0;
  logic narrow = 1'b0;
  logic extra = 1'b0;

  logic [10:0] x0, x1;
  logic [9:0]  y0, y1;
  logic        hs0, hs1, vs0, vs1, rt0, rt1, bl0, bl1, irq0, irq1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  tqvp_vga_timing_gen u_full (
    .clk(clk), .rst_n(rst_n), .cli(cli),
    .enable_interrupt_on_hblank(en_h), .enable_interrupt_on_vblank(en_v),
    .narrow_960(narrow), .extra_vblank_lines_for_64mhz(extra),
    .x(x0), .y(y0), .hsync(hs0), .vsync(vs0), .retrace(rt0), .blank(bl0), .interrupt(irq0)
  );

  tqvp_vga_timing_gen #(
    .H_VISIBLE(32), .H_NARROW(24), .H_FRONT(4), .H_SYNC(6), .H_BACK(8),
    .V_VISIBLE(20), .V_FRONT(2), .V_SYNC(3), .V_BACK_LONG(5), .V_BACK_SHORT(3)
  ) u_small (
    .clk(clk), .rst_n(rst_n), .cli(cli),
    .enable_interrupt_on_hblank(en_h), .enable_interrupt_on_vblank(en_v),
    .narrow_960(narrow), .extra_vblank_lines_for_64mhz(extra),
    .x(x1), .y(y1), .hsync(hs1), .vsync(vs1), .retrace(rt1), .blank(bl1), .interrupt(irq1)
  );

  // Timing of each instance: index 0 = full size, 1 = scaled
  int cfg_hvis[2] = '{1024, 32};
  int cfg_hnar[2] = '{960, 24};
  int cfg_hfp[2]  = '{24, 4};
  int cfg_hsw[2]  = '{136, 6};
  int cfg_hbp[2]  = '{144, 8};
  int cfg_vvis[2] = '{768, 20};
  int cfg_vfp[2]  = '{3, 2};
  int cfg_vsw[2]  = '{6, 3};
  int cfg_vbl[2]  = '{27, 5};
  int cfg_vbs[2]  = '{21, 3};

  typedef struct packed {
    logic [10:0] x;
    logic [9:0]  y;
    logic        hs;
    logic        vs;
    logic        rt;
    logic        bl;
    logic        irq;
  } obs_t;

  typedef struct packed {
    int x;
    int y;
    bit n;
    bit s;
    bit irq;
  } mst_t;

  mst_t m[2];

  function automatic obs_t act(input int d);
    obs_t o;
    if (d == 0) begin
      o.x = x0; o.y = y0; o.hs = hs0; o.vs = vs0; o.rt = rt0; o.bl = bl0; o.irq = irq0;
    end else begin
      o.x = x1; o.y = y1; o.hs = hs1; o.vs = vs1; o.rt = rt1; o.bl = bl1; o.irq = irq1;
    end
    return o;
  endfunction

  // Raster position advances as one linear index through the frame
  function automatic mst_t step(input int d, input mst_t s);
    mst_t r;
    int htot, vtot, hact, npos;
    htot = cfg_hvis[d] + cfg_hfp[d] + cfg_hsw[d] + cfg_hbp[d];
    vtot = cfg_vvis[d] + cfg_vfp[d] + cfg_vsw[d] + (s.s ? cfg_vbs[d] : cfg_vbl[d]);
    hact = s.n ? cfg_hnar[d] : cfg_hvis[d];
    npos = (s.y * htot + s.x + 1) % (htot * vtot);
    r = s;
    r.x = npos % htot;
    r.y = npos / htot;
    if (s.x == htot - 1) r.n = narrow;
    if (npos == 0) r.s = extra;
    if ((en_h && s.x == hact && s.y < cfg_vvis[d]) || (en_v && s.x == 0 && s.y == cfg_vvis[d]))
      r.irq = 1'b1;
    else if (cli)
      r.irq = 1'b0;
    return r;
  endfunction

  function automatic obs_t expect_obs(input int d, input mst_t s);
    obs_t o;
    int hact, hs_start, vs_start, htot;
    hact     = s.n ? cfg_hnar[d] : cfg_hvis[d];
    hs_start = cfg_hvis[d] + cfg_hfp[d];
    vs_start = cfg_vvis[d] + cfg_vfp[d];
    htot     = cfg_hvis[d] + cfg_hfp[d] + cfg_hsw[d] + cfg_hbp[d];
    o.x   = 11'(s.x);
    o.y   = 10'(s.y);
    o.hs  = !(s.x >= hs_start && s.x < hs_start + cfg_hsw[d]);
    o.vs  = !(s.y >= vs_start && s.y < vs_start + cfg_vsw[d]);
    o.rt  = (s.x == htot - 1);
    o.bl  = (s.x >= hact) || (s.y >= cfg_vvis[d]);
    o.irq = s.irq;
    return o;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m[0] <= '0;
      m[1] <= '0;
    end else begin
      m[0] <= step(0, m[0]);
      m[1] <= step(1, m[1]);
    end
  end

  // Every cycle out of reset, both instances must match the model
  always @(negedge clk) begin
    if (rst_n) begin
      for (int d = 0; d < 2; d++) begin
        obs_t a, e;
        a = act(d);
        e = expect_obs(d, m[d]);
        checks++;
        if (a !== e) begin
          errors++;
          if (errors <= 25)
            $display("FAIL track dut%0d t=%0t: got x=%0d y=%0d hs=%b vs=%b rt=%b bl=%b irq=%b, expected x=%0d y=%0d hs=%b vs=%b rt=%b bl=%b irq=%b",
                     d, $time, a.x, a.y, a.hs, a.vs, a.rt, a.bl, a.irq,
                     e.x, e.y, e.hs, e.vs, e.rt, e.bl, e.irq);
        end
      end
    end
  end

  task automatic check(input string name, input int d, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s dut%0d t=%0t: got %0d expected %0d", name, d, $time, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_pos(input int d, input int wx, input int wy, input int budget, input string name);
    obs_t a;
    int n;
    bit found;
    n = 0;
    found = 1'b0;
    while (!found && n < budget) begin
      a = act(d);
      if (int'(a.x) == wx && int'(a.y) == wy) found = 1'b1;
      else begin
        tick();
        n++;
      end
    end
    check(name, d, int'(found), 1);
  endtask

  // Runs the scaled instance from one (0,0) to the next
  task automatic measure_frame(input int flip_y, output int cyc, output int rc,
                               output int vl, output int vf);
    cyc = 0; rc = 0; vl = 0; vf = -1;
    do begin
      if (rt1) rc++;
      if (!vs1) begin
        vl++;
        if (vf < 0) vf = int'(y1);
      end
      if (flip_y >= 0 && x1 == 11'd0 && int'(y1) == flip_y) extra = 1'b1;
      tick();
      cyc++;
    end while (!(x1 == 11'd0 && y1 == 10'd0) && cyc < 5000);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got t=%0t expected completion", $time);
    $fatal(1);
  end

  initial begin
    obs_t a;
    int hs_cnt, hs_first, rt_cnt, rt_x, bad;
    int b10, b11, h11;
    int cyc, rc, vl, vf;

    // Reset state
    repeat (3) tick();
    a = act(0);
    check("reset_x", 0, int'(a.x), 0);
    check("reset_y", 0, int'(a.y), 0);
    check("reset_irq", 0, int'(a.irq), 0);
    check("reset_hsync", 0, int'(a.hs), 1);
    check("reset_vsync", 0, int'(a.vs), 1);
    check("reset_blank", 0, int'(a.bl), 0);
    check("reset_retrace", 0, int'(a.rt), 0);
    rst_n = 1'b1;

    // One full line of the full-size raster
    hs_cnt = 0; hs_first = -1; rt_cnt = 0; rt_x = -1; bad = 0;
    for (int i = 0; i < 1328; i++) begin
      @(negedge clk);
      a = act(0);
      if (int'(a.x) != i) bad++;
      if (!a.hs) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = int'(a.x);
      end
      if (a.rt) begin
        rt_cnt++;
        rt_x = int'(a.x);
      end
    end
    check("line_x_sequence_errors", 0, bad, 0);
    check("hsync_low_clocks", 0, hs_cnt, 136);
    check("hsync_first_x", 0, hs_first, 1048);
    check("retrace_count", 0, rt_cnt, 1);
    check("retrace_x", 0, rt_x, 1327);
    @(negedge clk);
    a = act(0);
    check("line2_x", 0, int'(a.x), 0);
    check("line2_y", 0, int'(a.y), 1);

    // Hblank interrupt: clear, then cli colliding with the set cycle
    tick();
    en_h = 1'b1;
    wait_pos(0, 1000, 5, 8000, "reach_y5_x1000");
    cli = 1'b1;
    tick();
    cli = 1'b0;
    check("hblank_cli_clear", 0, int'(irq0), 0);
    wait_pos(0, 1024, 5, 100, "reach_y5_x1024");
    check("hblank_before_set", 0, int'(irq0), 0);
    cli = 1'b1;
    tick();
    cli = 1'b0;
    en_h = 1'b0;
    check("hblank_set_wins", 0, int'(irq0), 1);

    // Narrow mode raised mid-line applies from the next line only
    wait_pos(0, 500, 10, 8000, "reach_y10_x500");
    narrow = 1'b1;
    b10 = -1; b11 = -1; h11 = -1;
    for (int i = 0; i < 4000; i++) begin
      @(negedge clk);
      a = act(0);
      if (a.y == 10'd12) break;
      if (a.y == 10'd10 && a.bl && b10 < 0) b10 = int'(a.x);
      if (a.y == 10'd11 && a.bl && b11 < 0) b11 = int'(a.x);
      if (a.y == 10'd11 && !a.hs && h11 < 0) h11 = int'(a.x);
    end
    check("narrow_line10_blank_x", 0, b10, 1024);
    check("narrow_line11_blank_x", 0, b11, 960);
    check("narrow_line11_hsync_x", 0, h11, 1048);
    tick();
    narrow = 1'b0;

    // Frame length on the scaled raster, switching length mid-frame
    wait_pos(1, 0, 0, 2000, "reach_frame_start");
    measure_frame(12, cyc, rc, vl, vf);
    check("frameA_cycles", 1, cyc, 1500);
    check("frameA_lines", 1, rc, 30);
    check("frameA_vsync_clocks", 1, vl, 150);
    check("frameA_vsync_first_y", 1, vf, 22);
    measure_frame(-1, cyc, rc, vl, vf);
    check("frameB_cycles", 1, cyc, 1400);
    check("frameB_lines", 1, rc, 28);
    check("frameB_vsync_clocks", 1, vl, 150);
    extra = 1'b0;

    // Vblank interrupt set, clear, and re-set only in the next frame
    en_v = 1'b1;
    cli = 1'b1;
    tick();
    cli = 1'b0;
    wait_pos(1, 0, 20, 2000, "reach_vblank");
    check("vblank_before_set", 1, int'(irq1), 0);
    tick();
    check("vblank_set", 1, int'(irq1), 1);
    wait_pos(1, 0, 22, 500, "reach_y22");
    cli = 1'b1;
    tick();
    cli = 1'b0;
    check("vblank_cli_clear", 1, int'(irq1), 0);
    wait_pos(1, 0, 20, 2000, "reach_next_vblank");
    check("vblank_held_low", 1, int'(irq1), 0);
    tick();
    check("vblank_reset_next", 1, int'(irq1), 1);
    en_v = 1'b0;
    tick();
    check("enable_drop_keeps_irq", 1, int'(irq1), 1);

    // No hblank sets on vblank lines
    cli = 1'b1;
    tick();
    cli = 1'b0;
    en_h = 1'b1;
    wait_pos(1, 49, 29, 1000, "reach_last_line_end");
    check("no_hblank_in_vblank", 1, int'(irq1), 0);

    // Asynchronous reset mid-frame with a pending interrupt
    wait_pos(1, 30, 10, 2000, "reach_y10_x30");
    check("pre_reset_irq", 1, int'(irq1), 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("async_x", 1, int'(x1), 0);
    check("async_y", 1, int'(y1), 0);
    check("async_irq", 1, int'(irq1), 0);
    check("async_x_full", 0, int'(x0), 0);
    check("async_y_full", 0, int'(y0), 0);
    tick();
    rst_n = 1'b1;
    en_h = 1'b0;
    repeat (5) tick();
    check("restart_x", 1, int'(x1), 5);
    check("restart_y", 1, int'(y1), 0);
    check("restart_x_full", 0, int'(x0), 5);
    check("restart_irq", 1, int'(irq1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/tqvp_vga_timing_gen.md
Name: tqvp_vga_timing_gen

Overview:
- Scan-timing generator that feeds the TinyQV VGA peripheral directly upstream.
- Produces raster counters, sync, blanking, a per-scanline retrace strobe and a sticky CPU interrupt for a 1024x768 (or 960x768 narrow) raster at ~60 Hz from the 64 MHz (or 63.5 MHz) project clock.
- The peripheral consumes x/y/blank/retrace to walk VRAM, forwards hsync/vsync to the PMOD, and drives cli/enables from its register writes.

Parameters:
- H_VISIBLE, 1024, visible clocks per line (wide mode)
- H_NARROW, 960, visible clocks per line when narrow_960=1
- H_FRONT, 24, horizontal front porch clocks
- H_SYNC, 136, hsync pulse clocks
- H_BACK, 144, horizontal back porch clocks (H_TOTAL = 1328)
- V_VISIBLE, 768, visible lines
- V_FRONT, 3, vertical front porch lines
- V_SYNC, 6, vsync pulse lines
- V_BACK_LONG, 27, back porch lines in 64 MHz mode (V_TOTAL = 804)
- V_BACK_SHORT, 21, back porch lines in 63.5 MHz mode (V_TOTAL = 798)

Ports:
- clk  input  1  project clock, 64 MHz nominal
- rst_n  input  1  asynchronous active-low reset
- cli  input  1  clear interrupt; any CPU write to the peripheral
- enable_interrupt_on_hblank  input  1  set interrupt at start of each visible line's hblank
- enable_interrupt_on_vblank  input  1  set interrupt at start of vblank
- narrow_960  input  1  0: 1024 visible clocks, 1: 960 visible clocks
- extra_vblank_lines_for_64mhz  input  1  0: 804-line frame (64 MHz), 1: 798-line frame (63.5 MHz)
- x  output  11  horizontal counter, 0..1327
- y  output  10  vertical counter, 0..V_TOTAL-1
- hsync  output  1  horizontal sync, active low
- vsync  output  1  vertical sync, active low
- retrace  output  1  one-cycle strobe on last clock of every line
- blank  output  1  high outside active picture
- interrupt  output  1  sticky interrupt request, level

Behaviour:
- Reset: clk and rst_n as the codebase names them; reset is asynchronous and active-low. While rst_n=0: x=0, y=0, interrupt=0, mode latches = {narrow 0, short-frame 0}.
- After reset: hsync=1, vsync=1, blank=0, retrace=0 (derived from x=0, y=0).
- x increments every clock. At x=1327 it wraps to 0 and y increments. At y=V_TOTAL-1 with x=1327, y wraps to 0.
- Mode latching:
  - narrow_960 is sampled into latch n_q at x=1327, so it applies from the next line.
  - extra_vblank_lines_for_64mhz is sampled into latch s_q at the frame wrap (y=V_TOTAL-1, x=1327), so it applies from the next frame.
  - Consequence: a mid-frame change never truncates or extends the current frame.
- V_TOTAL = 804 if s_q=0, else 798. H_ACTIVE = 960 if n_q=1, else 1024.
- Decodes are combinational from the x/y registers and valid in the same cycle as x/y:
  - blank = (x >= H_ACTIVE) or (y >= 768). In narrow mode x 960..1023 is blanked.
  - hsync = 0 for x in [1048, 1184) (H_VISIBLE+H_FRONT .. +H_SYNC), independent of narrow mode. The sync position is fixed.
  - vsync = 0 for y in [771, 777).
  - retrace = (x == 1327), on every line including vblank lines.
- Interrupt:
  - set_h = enable_interrupt_on_hblank & (x == H_ACTIVE) & (y < 768).
  - set_v = enable_interrupt_on_vblank & (x == 0) & (y == 768).
  - Next-state: if (set_h or set_v), interrupt <= 1; else if cli, interrupt <= 0; else hold. Set wins over a simultaneous cli.
  - Enables gate only new set events. Deasserting an enable does not clear a pending interrupt.
- Latency: retrace-to-x=0 is exactly 1 clock. Interrupt rises 1 clock after the qualifying x/y.
- Reset mid-frame returns immediately to x=0, y=0, dropping any pending interrupt. No partial-frame state survives.
- Width rules: x is 11-bit unsigned and y is 10-bit unsigned. Comparisons use full counter width; no counter ever exceeds its total.

Test Plan:
- Reset/line timing: release rst_n, run 1328 clocks -> x counts 0..1327 then 0; hsync low exactly for x=1048..1183 (136 clocks); retrace high only at x=1327; y=1 at the second line's x=0.
- Frame length: extra=0, count retrace pulses between y=0 returns -> 804 lines, vsync low for y=771..776. Set extra=1 at y=400 -> current frame still 804 lines, next frame 798.
- Narrow blanking: narrow_960=1 asserted at y=10, x=500 -> line 10 blank rises at x=1024; line 11 blank rises at x=960; hsync edges unchanged.
- Vblank interrupt: enable_vblank=1 -> interrupt rises the clock after (x=0, y=768); pulse cli at y=780 -> interrupt 0 next clock; no re-set until the next frame's y=768.
- Hblank interrupt and collision: enable_hblank=1, narrow=0, cli asserted in the same cycle as x=1024, y=5 -> interrupt=1 (set wins); no hblank set occurs on lines y>=768.
- Async reset mid-frame: drop rst_n at x=700, y=300 with interrupt=1 -> x, y, interrupt read 0 without a clock edge; after release, counting restarts from x=0, y=0.
